alu_issue_ctrl: RTL

Multi-cycle issue/writeback controller sitting directly upstream of the ALU. It accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal 4x8 register file. It drives the ALU opcode and operand buses from registers, captures the ALU result and flags one cycle later, and writes the result back. It owns the architectural flag register (Z, C, N) that the rest of the CPU reads.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the ALU issue/writeback controller.
//   - DW: datapath width (must match the ALU)
//   - OP_*: 4-bit instruction opcodes
//   - *_LSB: bit offsets of the instruction fields
//   - state_t: controller FSM states
//   - is_alu_op(): true for opcodes that go through the ALU
package cpu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_LOADI = 4'd5;

  // Instruction layout: [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm8
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 8;
  localparam int RS2_LSB = 6;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: small architectural register file.
//   clk, rst         : clock, asynchronous active-high reset (clears all entries)
//   we/waddr/wdata   : synchronous write port
//   raddr_a/rdata_a  : combinational read port A
//   raddr_b/rdata_b  : combinational read port B
//   dbg_sel/dbg_data : combinational debug read port
module alu_regfile #(
  parameter int NREGS = 4,
  parameter int DW    = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: serial issue/writeback controller placed in front of an
// external combinational ALU.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_instr/in_ready : instruction handshake (one in flight at a time)
//   alu_opcode/alu_a/alu_b   : registered ALU inputs
//   alu_result, alu_zero/carry/neg : ALU outputs, captured during EXEC
//   done/err/wb_data         : retirement pulse, illegal-op flag, written value
//   flags                    : architectural {Z,C,N}
//   dbg_sel/dbg_data         : combinational register file peek
module alu_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int DW    = cpu_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  output logic [7:0]    alu_opcode,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic          alu_carry,
  input  logic          alu_neg,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] wb_data,
  output logic [2:0]    flags,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [7:0]    alu_opcode_q, alu_opcode_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [DW-1:0] res_q, res_d;      // ALU result captured in EXEC
  logic [2:0]    cflags_q, cflags_d; // ALU flags captured in EXEC
  logic [2:0]    flags_q, flags_d;

  logic [OP_W-1:0] op;
  logic [AW-1:0]   rd, rs1, rs2;
  logic [DW-1:0]   imm;
  logic [DW-1:0]   rdata_a, rdata_b;
  logic            rf_we;
  logic [DW-1:0]   rf_wdata;

  assign op  = instr_q[OP_LSB +: OP_W];
  assign rd  = instr_q[RD_LSB +: AW];
  assign rs1 = instr_q[RS1_LSB +: AW];
  assign rs2 = instr_q[RS2_LSB +: AW];
  assign imm = instr_q[IMM_LSB +: DW];

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (rf_wdata),
    .raddr_a  (rs1),
    .rdata_a  (rdata_a),
    .raddr_b  (rs2),
    .rdata_b  (rdata_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      res_q        <= '0;
      cflags_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      res_q        <= res_d;
      cflags_q     <= cflags_d;
      flags_q      <= flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    res_d        = res_q;
    cflags_d     = cflags_q;
    flags_d      = flags_q;
    in_ready     = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    wb_data      = '0;
    rf_we        = 1'b0;
    rf_wdata     = '0;

    unique case (state_q)
      IDLE: begin
        // Reset forces IDLE asynchronously; keep ready low until it is released.
        in_ready = !rst;
        if (in_valid && !rst) begin
          instr_d = in_instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Operands are sampled here, so rd==rs reads the pre-write value.
        alu_opcode_d = 8'(op);
        alu_a_d      = rdata_a;
        alu_b_d      = rdata_b;
        state_d      = is_alu_op(op) ? EXEC : WB;
      end
      EXEC: begin
        res_d    = alu_result;
        cflags_d = {alu_zero, alu_carry, alu_neg};
        state_d  = WB;
      end
      WB: begin
        done = 1'b1;
        if (is_alu_op(op)) begin
          rf_we    = 1'b1;
          rf_wdata = res_q;
          wb_data  = res_q;
          flags_d  = cflags_q;
        end else if (op == OP_LOADI) begin
          rf_we    = 1'b1;
          rf_wdata = imm;
          wb_data  = imm;
        end else begin
          err = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign flags      = flags_q;

endmodule
